capture_seq: RTL and testbench

- Capture sequencer that drives the timing generator's trigger input, replacing the constant trigger tie-off in the top level.
- On a CPU start request it runs N flush frames to clear the CCD, holds an exposure interval, then triggers and tracks one capture frame.
- Gates the CPU readout-valid flag and reports completion and errors.
- Sits between the CPU control interface and timgen, in the clk_pix domain.

---
 rtl/capture_seq.sv | 155 +++++++++++++++
 tb/tb_capture_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_seq.sv
// Capture sequencer: flush frames, exposure interval, then one triggered capture frame.
// Optional continuous mode when CAPTURE_SEQ_CONTINUOUS_EN is defined (adds the cont input).
module capture_seq #(
  parameter int unsigned EXP_W   = 24,
  parameter int unsigned FLUSH_W = 4,
  parameter int unsigned TIMEOUT = 2000000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk_pix,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
`ifdef CAPTURE_SEQ_CONTINUOUS_EN
  input  logic               cont,
`endif
  input  logic [FLUSH_W-1:0] cfg_flush,
  input  logic [EXP_W-1:0]   cfg_exp,
  input  logic               tg_done,
  output logic               tg_trigger,
  output logic               exp_active,
  output logic               cap_active,
  output logic               busy,
  output logic               cap_done,
  output logic               err,
  output logic [CNT_W-1:0]   cap_cnt
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FL_TRIG, S_FL_WAIT, S_EXPOSE, S_CAP_TRIG, S_CAP_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic [EXP_W-1:0]   exp_cfg_q, exp_cfg_d;
  logic [EXP_W-1:0]   exp_cnt_q, exp_cnt_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               cont_q, cont_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cap_cnt_q, cap_cnt_d;
  logic               tg_trigger_q, tg_trigger_d;
  logic               exp_active_q, exp_active_d;
  logic               cap_active_q, cap_active_d;
  logic               busy_q, busy_d;
  logic               cap_done_q, cap_done_d;

  logic               waiting_c, wd_expired_c, accept_c, timeout_c, frame_done_c;
  logic [EXP_W-1:0]   exp_load_c;

  assign waiting_c    = (state_q == S_FL_WAIT) || (state_q == S_CAP_WAIT);
  assign wd_expired_c = (wd_q == WD_W'(TIMEOUT - 1));
  assign accept_c     = (state_q == S_IDLE) && start && !abort;
  assign timeout_c    = waiting_c && !tg_done && !abort && wd_expired_c;
  assign frame_done_c = (state_q == S_CAP_WAIT) && tg_done && !abort;

  always_ff @(posedge clk_pix) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state; abort from any busy state overrides everything else.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept_c) state_d = (cfg_flush != '0) ? S_FL_TRIG : S_EXPOSE;
      S_FL_TRIG:  state_d = S_FL_WAIT;
      S_FL_WAIT: begin
        if (tg_done)           state_d = (flush_q == FLUSH_W'(1)) ? S_EXPOSE : S_FL_TRIG;
        else if (wd_expired_c) state_d = S_IDLE;
      end
      S_EXPOSE:   if (exp_cnt_q == '0) state_d = S_CAP_TRIG;
      S_CAP_TRIG: state_d = S_CAP_WAIT;
      S_CAP_WAIT: begin
        if (tg_done)           state_d = cont_q ? S_EXPOSE : S_IDLE;
        else if (wd_expired_c) state_d = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Datapath and registered-output next values.
  always_comb begin
    flush_d    = flush_q;
    exp_cfg_d  = exp_cfg_q;
    cont_d     = cont_q;
    err_d      = err_q;
    exp_cnt_d  = exp_cnt_q;
    exp_load_c = accept_c ? cfg_exp : exp_cfg_q;
    if (accept_c) begin
      flush_d   = cfg_flush;
      exp_cfg_d = cfg_exp;
      err_d     = 1'b0;
`ifdef CAPTURE_SEQ_CONTINUOUS_EN
      cont_d    = cont;
`else
      cont_d    = 1'b0;
`endif
    end
    if ((state_q == S_FL_WAIT) && tg_done && !abort) flush_d = flush_q - FLUSH_W'(1);
    if (timeout_c) err_d = 1'b1;
    // Counter is preloaded one short so the exposure lasts max(cfg_exp,1) cycles.
    if ((state_d == S_EXPOSE) && (state_q != S_EXPOSE))
      exp_cnt_d = (exp_load_c == '0) ? '0 : exp_load_c - EXP_W'(1);
    else if ((state_q == S_EXPOSE) && (exp_cnt_q != '0))
      exp_cnt_d = exp_cnt_q - EXP_W'(1);
    wd_d         = waiting_c ? wd_q + WD_W'(1) : '0;
    cap_done_d   = frame_done_c;
    cap_cnt_d    = cap_cnt_q + CNT_W'(frame_done_c);
    tg_trigger_d = (state_d == S_FL_TRIG) || (state_d == S_CAP_TRIG);
    exp_active_d = (state_d == S_EXPOSE);
    cap_active_d = (state_d == S_CAP_TRIG) || (state_d == S_CAP_WAIT);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      flush_q      <= '0;
      exp_cfg_q    <= '0;
      exp_cnt_q    <= '0;
      wd_q         <= '0;
      cont_q       <= 1'b0;
      err_q        <= 1'b0;
      cap_cnt_q    <= '0;
      tg_trigger_q <= 1'b0;
      exp_active_q <= 1'b0;
      cap_active_q <= 1'b0;
      busy_q       <= 1'b0;
      cap_done_q   <= 1'b0;
    end else begin
      flush_q      <= flush_d;
      exp_cfg_q    <= exp_cfg_d;
      exp_cnt_q    <= exp_cnt_d;
      wd_q         <= wd_d;
      cont_q       <= cont_d;
      err_q        <= err_d;
      cap_cnt_q    <= cap_cnt_d;
      tg_trigger_q <= tg_trigger_d;
      exp_active_q <= exp_active_d;
      cap_active_q <= cap_active_d;
      busy_q       <= busy_d;
      cap_done_q   <= cap_done_d;
    end
  end

  assign tg_trigger = tg_trigger_q;
  assign exp_active = exp_active_q;
  assign cap_active = cap_active_q;
  assign busy       = busy_q;
  assign cap_done   = cap_done_q;
  assign err        = err_q;
  assign cap_cnt    = cap_cnt_q;

endmodule

// File: tb/tb_capture_seq.sv
// Directed self-checking bench for capture_seq (TIMEOUT reduced to 100 cycles).
module tb_capture_seq;

  logic        clk_pix = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
`ifdef CAPTURE_SEQ_CONTINUOUS_EN
  logic        cont = 1'b0;
`endif
  logic [3:0]  cfg_flush = '0;
  logic [23:0] cfg_exp = '0;
  logic        tg_done = 1'b0;
  logic        tg_trigger, exp_active, cap_active, busy, cap_done, err;
  logic [15:0] cap_cnt;

  int n_checks = 0;
  int n_pass = 0;

  // Per-run observations, cycle 0 being the cycle start is driven.
  int n_trig, n_exp, exp_first, n_done, cap_first, cap_last, end_cyc, err_first;
  logic err_c1;
  int trig_cyc[16];
  int done_cyc[16];
  int cnt_at_done[16];

  capture_seq #(.TIMEOUT(100)) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef CAPTURE_SEQ_CONTINUOUS_EN
    .cont(cont),
`endif
    .cfg_flush(cfg_flush), .cfg_exp(cfg_exp), .tg_done(tg_done),
    .tg_trigger(tg_trigger), .exp_active(exp_active), .cap_active(cap_active),
    .busy(busy), .cap_done(cap_done), .err(err), .cap_cnt(cap_cnt)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  // Issues start, answers each trigger with tg_done after dly cycles (0 = never),
  // optionally aborts alongside a given done or after a number of cap_done pulses.
  task automatic run_seq(input logic [3:0] fl, input logic [23:0] ex, input int dly,
                         input int abort_trig, input int abort_caps, input int max_cyc);
    n_trig = 0; n_exp = 0; exp_first = -1; n_done = 0; cap_first = -1; cap_last = -1;
    end_cyc = -1; err_first = -1; err_c1 = 1'bx;
    for (int i = 0; i < 16; i++) begin
      trig_cyc[i] = -1; done_cyc[i] = -1; cnt_at_done[i] = -1;
    end
    cfg_flush = fl; cfg_exp = ex; start = 1'b1; tg_done = 1'b0; abort = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      step();
      start = 1'b0; tg_done = 1'b0; abort = 1'b0;
      if (tg_trigger) begin
        if (n_trig < 16) trig_cyc[n_trig] = c;
        n_trig++;
      end
      if (exp_active) begin
        if (exp_first < 0) exp_first = c;
        n_exp++;
      end
      if (cap_active) begin
        if (cap_first < 0) cap_first = c;
        cap_last = c;
      end
      if (cap_done) begin
        if (n_done < 16) begin
          done_cyc[n_done] = c;
          cnt_at_done[n_done] = int'(cap_cnt);
        end
        n_done++;
      end
      if (err && err_first < 0) err_first = c;
      if (c == 1) err_c1 = err;
      if (!busy) begin
        end_cyc = c;
        break;
      end
      if (dly > 0)
        for (int i = 0; i < 16; i++)
          if (i < n_trig && trig_cyc[i] + dly == c) begin
            tg_done = 1'b1;
            if (i == abort_trig) abort = 1'b1;
          end
      if (abort_caps > 0 && n_done == abort_caps) abort = 1'b1;
    end
    start = 1'b0; tg_done = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_checks++; if ({tg_trigger, exp_active, cap_active, busy, cap_done, err} !== 6'b0)
      $display("FAIL reset.flags got=%b exp=000000", {tg_trigger, exp_active, cap_active, busy, cap_done, err}); else n_pass++;
    n_checks++; if (cap_cnt !== 16'd0) $display("FAIL reset.cap_cnt got=%0d exp=0", cap_cnt); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_flush_capture();
    run_seq(4'd2, 24'd5, 10, -1, 0, 200);
    n_checks++; if (n_trig !== 3) $display("FAIL flush.n_trig got=%0d exp=3", n_trig); else n_pass++;
    n_checks++; if (trig_cyc[0] !== 1) $display("FAIL flush.trig0 got=%0d exp=1", trig_cyc[0]); else n_pass++;
    n_checks++; if (trig_cyc[1] !== 12) $display("FAIL flush.trig1 got=%0d exp=12", trig_cyc[1]); else n_pass++;
    n_checks++; if (trig_cyc[2] !== 28) $display("FAIL flush.trig2 got=%0d exp=28", trig_cyc[2]); else n_pass++;
    n_checks++; if (n_exp !== 5 || exp_first !== 23)
      $display("FAIL flush.expose got=%0d@%0d exp=5@23", n_exp, exp_first); else n_pass++;
    n_checks++; if (cap_first !== 28 || cap_last !== 38)
      $display("FAIL flush.cap_active got=%0d..%0d exp=28..38", cap_first, cap_last); else n_pass++;
    n_checks++; if (n_done !== 1 || done_cyc[0] !== 39)
      $display("FAIL flush.cap_done got=%0d@%0d exp=1@39", n_done, done_cyc[0]); else n_pass++;
    n_checks++; if (end_cyc !== 39) $display("FAIL flush.busy_drop got=%0d exp=39", end_cyc); else n_pass++;
    n_checks++; if (cap_cnt !== 16'd1) $display("FAIL flush.cap_cnt got=%0d exp=1", cap_cnt); else n_pass++;
  endtask

  task automatic test_no_flush_zero_exp();
    run_seq(4'd0, 24'd0, 4, -1, 0, 100);
    n_checks++; if (n_exp !== 1 || exp_first !== 1)
      $display("FAIL exp0.expose got=%0d@%0d exp=1@1", n_exp, exp_first); else n_pass++;
    n_checks++; if (n_trig !== 1 || trig_cyc[0] !== 2)
      $display("FAIL exp0.trig got=%0d@%0d exp=1@2", n_trig, trig_cyc[0]); else n_pass++;
    n_checks++; if (cap_first !== 2 || cap_last !== 6)
      $display("FAIL exp0.cap_active got=%0d..%0d exp=2..6", cap_first, cap_last); else n_pass++;
    n_checks++; if (n_done !== 1 || done_cyc[0] !== 7 || cnt_at_done[0] !== 2)
      $display("FAIL exp0.cap_done got=%0d@%0d cnt=%0d exp=1@7 cnt=2", n_done, done_cyc[0], cnt_at_done[0]); else n_pass++;
  endtask

  task automatic test_timeout();
    run_seq(4'd1, 24'd2, 0, -1, 0, 300);
    n_checks++; if (n_trig !== 1) $display("FAIL timeout.n_trig got=%0d exp=1", n_trig); else n_pass++;
    n_checks++; if (err_first !== 102) $display("FAIL timeout.err_cycle got=%0d exp=102", err_first); else n_pass++;
    n_checks++; if (end_cyc !== 102) $display("FAIL timeout.busy_drop got=%0d exp=102", end_cyc); else n_pass++;
    n_checks++; if (n_done !== 0 || cap_cnt !== 16'd2)
      $display("FAIL timeout.no_capture got=%0d cnt=%0d exp=0 cnt=2", n_done, cap_cnt); else n_pass++;
    step();
    step();
    n_checks++; if (err !== 1'b1) $display("FAIL timeout.err_sticky got=%b exp=1", err); else n_pass++;
  endtask

  task automatic test_err_clear();
    run_seq(4'd0, 24'd3, 2, -1, 0, 100);
    n_checks++; if (err_c1 !== 1'b0) $display("FAIL errclr.err got=%b exp=0", err_c1); else n_pass++;
    n_checks++; if (n_exp !== 3 || trig_cyc[0] !== 4)
      $display("FAIL errclr.latency got=%0d@%0d exp=3@4", n_exp, trig_cyc[0]); else n_pass++;
    n_checks++; if (n_done !== 1 || cap_cnt !== 16'd3)
      $display("FAIL errclr.capture got=%0d cnt=%0d exp=1 cnt=3", n_done, cap_cnt); else n_pass++;
  endtask

  task automatic test_abort();
    run_seq(4'd0, 24'd1, 3, 0, 0, 100);
    n_checks++; if (end_cyc !== 6 || cap_last !== 5)
      $display("FAIL abort.idle got=%0d last_cap=%0d exp=6 last_cap=5", end_cyc, cap_last); else n_pass++;
    n_checks++; if (n_done !== 0 || cap_cnt !== 16'd3)
      $display("FAIL abort.no_done got=%0d cnt=%0d exp=0 cnt=3", n_done, cap_cnt); else n_pass++;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || tg_trigger !== 1'b0)
      $display("FAIL abort.start_collide busy=%b trig=%b exp=0 0", busy, tg_trigger); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid_frame();
    cfg_flush = 4'd0; cfg_exp = 24'd0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n_checks++; if (cap_active !== 1'b1) $display("FAIL rstmid.cap_active got=%b exp=1", cap_active); else n_pass++;
    rst_n = 1'b0;
    step();
    n_checks++; if ({tg_trigger, exp_active, cap_active, busy, cap_done, err} !== 6'b0 || cap_cnt !== 16'd0)
      $display("FAIL rstmid.cleared flags=%b cnt=%0d exp=000000 cnt=0",
               {tg_trigger, exp_active, cap_active, busy, cap_done, err}, cap_cnt); else n_pass++;
    rst_n = 1'b1; tg_done = 1'b1;
    step();
    tg_done = 1'b0;
    n_checks++; if (cap_done !== 1'b0 || busy !== 1'b0 || cap_cnt !== 16'd0)
      $display("FAIL rstmid.done_ignored done=%b busy=%b cnt=%0d exp=0 0 0", cap_done, busy, cap_cnt); else n_pass++;
    step();
  endtask

`ifdef CAPTURE_SEQ_CONTINUOUS_EN
  task automatic test_continuous();
    cont = 1'b1;
    run_seq(4'd0, 24'd3, 2, -1, 3, 200);
    cont = 1'b0;
    n_checks++; if (n_done !== 3) $display("FAIL cont.n_done got=%0d exp=3", n_done); else n_pass++;
    n_checks++; if (done_cyc[0] !== 7 || done_cyc[1] !== 13 || done_cyc[2] !== 19)
      $display("FAIL cont.done_cycles got=%0d,%0d,%0d exp=7,13,19", done_cyc[0], done_cyc[1], done_cyc[2]); else n_pass++;
    n_checks++; if (cnt_at_done[0] !== 1 || cnt_at_done[1] !== 2 || cnt_at_done[2] !== 3)
      $display("FAIL cont.cnt_seq got=%0d,%0d,%0d exp=1,2,3", cnt_at_done[0], cnt_at_done[1], cnt_at_done[2]); else n_pass++;
    n_checks++; if (n_trig !== 3 || end_cyc !== 20)
      $display("FAIL cont.abort_idle trig=%0d end=%0d exp=3 20", n_trig, end_cyc); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_flush_capture();
    test_no_flush_zero_exp();
    test_timeout();
    test_err_clear();
    test_abort();
    test_reset_mid_frame();
`ifdef CAPTURE_SEQ_CONTINUOUS_EN
    test_continuous();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
